// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: shares the multiplexed RTC address/data bus between the
// periodic read sequencer and the user write path. It runs one full
// address+data transaction per grant, with programmable phase timing.
module rtc_bus_arbiter #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PULSE = 4,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_GAP   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  input  logic       rd_req,
  input  logic [7:0] rd_addr,
  output logic       rd_done,
  output logic [7:0] rd_data,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_done,
  output logic       busy,
  output logic       cs_n,
  output logic       ad_sel,
  output logic       rd_n,
  output logic       wr_n,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  typedef enum logic [2:0] {
    IDLE, A_SETUP, A_PULSE, A_HOLD, D_SETUP, D_PULSE, D_HOLD, GAP
  } state_t;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_t;

  localparam logic [3:0] LD_SETUP = 4'(T_SETUP);
  localparam logic [3:0] LD_PULSE = 4'(T_PULSE);
  localparam logic [3:0] LD_HOLD  = 4'(T_HOLD);
  localparam logic [3:0] LD_GAP   = 4'(T_GAP);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  dir_t       dir_q, dir_d;
  dir_t       last_q, last_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_done_q, rd_done_d;
  logic       wr_done_q, wr_done_d;
  logic       busy_q, busy_d;
  logic       cs_n_q, cs_n_d;
  logic       ad_sel_q, ad_sel_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic [7:0] ad_out_q, ad_out_d;
  logic       ad_oe_q, ad_oe_d;
  logic       grant_wr;

  // Next-state logic: arbitration in IDLE, phase counter sequencing elsewhere.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    grant_wr = 1'b0;
    if (state_q == IDLE) begin
      if (!hold && (rd_req || wr_req)) begin
        // Both pending: round-robin away from the previous winner.
        grant_wr = wr_req && (!rd_req || (last_q == DIR_RD));
        dir_d    = grant_wr ? DIR_WR : DIR_RD;
        last_d   = grant_wr ? DIR_WR : DIR_RD;
        addr_d   = grant_wr ? wr_addr : rd_addr;
        if (grant_wr) begin
          wdata_d = wr_data;
        end
        state_d = A_SETUP;
        cnt_d   = LD_SETUP;
      end
    end else if (cnt_q == 4'd1) begin
      unique case (state_q)
        A_SETUP: begin state_d = A_PULSE; cnt_d = LD_PULSE; end
        A_PULSE: begin state_d = A_HOLD;  cnt_d = LD_HOLD;  end
        A_HOLD:  begin state_d = D_SETUP; cnt_d = LD_SETUP; end
        D_SETUP: begin state_d = D_PULSE; cnt_d = LD_PULSE; end
        D_PULSE: begin state_d = D_HOLD;  cnt_d = LD_HOLD;  end
        D_HOLD:  begin state_d = GAP;     cnt_d = LD_GAP;   end
        default: begin state_d = IDLE;    cnt_d = '0;       end
      endcase
    end else begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Output decode from the upcoming state so every pin is registered yet
  // changes in the same cycle the state register does.
  always_comb begin
    cs_n_d    = 1'b1;
    ad_sel_d  = 1'b1;
    rd_n_d    = 1'b1;
    wr_n_d    = 1'b1;
    ad_oe_d   = 1'b0;
    ad_out_d  = ad_out_q;
    busy_d    = (state_d != IDLE);
    rd_done_d = (state_q == D_HOLD) && (state_d == GAP) && (dir_q == DIR_RD);
    wr_done_d = (state_q == D_HOLD) && (state_d == GAP) && (dir_q == DIR_WR);
    rd_data_d = rd_data_q;
    if ((state_q == D_PULSE) && (cnt_q == 4'd1) && (dir_q == DIR_RD)) begin
      rd_data_d = ad_in;
    end
    unique case (state_d)
      A_SETUP, A_HOLD, A_PULSE: begin
        cs_n_d   = 1'b0;
        ad_sel_d = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d;
        wr_n_d   = (state_d != A_PULSE);
      end
      D_SETUP, D_PULSE, D_HOLD: begin
        cs_n_d = 1'b0;
        if (dir_d == DIR_WR) begin
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_d;
          wr_n_d   = (state_d != D_PULSE);
        end else begin
          rd_n_d = (state_d != D_PULSE);
        end
      end
      default: ;
    endcase
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dir_q     <= DIR_RD;
      last_q    <= DIR_RD;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      busy_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      ad_sel_q  <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      ad_out_q  <= '0;
      ad_oe_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      rd_done_q <= rd_done_d;
      wr_done_q <= wr_done_d;
      busy_q    <= busy_d;
      cs_n_q    <= cs_n_d;
      ad_sel_q  <= ad_sel_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      ad_out_q  <= ad_out_d;
      ad_oe_q   <= ad_oe_d;
    end
  end

  assign rd_done = rd_done_q;
  assign rd_data = rd_data_q;
  assign wr_done = wr_done_q;
  assign busy    = busy_q;
  assign cs_n    = cs_n_q;
  assign ad_sel  = ad_sel_q;
  assign rd_n    = rd_n_q;
  assign wr_n    = wr_n_q;
  assign ad_out  = ad_out_q;
  assign ad_oe   = ad_oe_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Scoreboard bench for rtc_bus_arbiter: stimulus pushes expected
// transactions, a negedge monitor pops them on each done pulse.
module tb_rtc_bus_arbiter;

  localparam int T_SETUP = 2;
  localparam int T_PULSE = 4;
  localparam int T_HOLD  = 2;
  localparam int T_GAP   = 4;
  localparam int LAT     = 1 + 2 * (T_SETUP + T_PULSE + T_HOLD); // 17
  localparam int PERIOD  = LAT + T_GAP;                          // 21

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       hold = 1'b0;
  logic       rd_req = 1'b0;
  logic [7:0] rd_addr = '0;
  logic       rd_done;
  logic [7:0] rd_data;
  logic       wr_req = 1'b0;
  logic [7:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       wr_done;
  logic       busy;
  logic       cs_n;
  logic       ad_sel;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [7:0] ad_in = '0;

  rtc_bus_arbiter #(
    .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD), .T_GAP(T_GAP)
  ) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_done(rd_done), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
    .busy(busy), .cs_n(cs_n), .ad_sel(ad_sel), .rd_n(rd_n), .wr_n(wr_n),
    .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  typedef struct {
    bit         w;
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  // Bus observation accumulated over one transaction.
  int         a_cnt = 0, r_cnt = 0, w_cnt = 0;
  logic [7:0] a_addr = '0, w_dat = '0;
  bit         w_oe = 1'b1;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check("strobes_exclusive", {31'd0, (rd_n === 1'b0 && wr_n === 1'b0)}, 0);
      check("no_drive_while_read", {31'd0, (ad_oe === 1'b1 && rd_n === 1'b0)}, 0);
      if (!cs_n && !ad_sel && !wr_n) begin a_cnt++; a_addr = ad_out; end
      if (!cs_n && ad_sel && !rd_n) r_cnt++;
      if (!cs_n && ad_sel && !wr_n) begin w_cnt++; w_dat = ad_out; w_oe &= ad_oe; end
      if (rd_done === 1'b1 || wr_done === 1'b1) begin
        check("single_done", {31'd0, (rd_done === 1'b1 && wr_done === 1'b1)}, 0);
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_dir", {31'd0, wr_done}, {31'd0, e.w});
          check("done_cycle", cyc, e.cyc);
          check("addr_strobe_len", a_cnt, T_PULSE);
          check("addr_value", {24'd0, a_addr}, {24'd0, e.addr});
          if (e.w) begin
            check("wr_strobe_len", w_cnt, T_PULSE);
            check("wr_bus_data", {24'd0, w_dat}, {24'd0, e.data});
            check("wr_bus_oe", {31'd0, w_oe}, 1);
            check("wr_no_rd_strobe", r_cnt, 0);
          end else begin
            check("rd_strobe_len", r_cnt, T_PULSE);
            check("rd_data", {24'd0, rd_data}, {24'd0, e.data});
            check("rd_no_wr_strobe", w_cnt, 0);
          end
        end
        a_cnt = 0; r_cnt = 0; w_cnt = 0; w_oe = 1'b1;
      end
    end else begin
      a_cnt = 0; r_cnt = 0; w_cnt = 0; w_oe = 1'b1;
    end
  end

  task automatic wait_dones(input int n, input int budget);
    int seen = 0;
    for (int i = 0; i < budget && seen < n; i++) begin
      @(negedge clk);
      if (rd_done === 1'b1 || wr_done === 1'b1) seen++;
    end
    check("done_count", seen, n);
  endtask

  task automatic single(input bit w, input logic [7:0] a, input logic [7:0] d, input logic [7:0] din);
    exp_t e;
    @(posedge clk); #1;
    ad_in = din;
    if (w) begin wr_req = 1'b1; wr_addr = a; wr_data = d; end
    else   begin rd_req = 1'b1; rd_addr = a; end
    e.w = w; e.addr = a; e.data = w ? d : din; e.cyc = cyc + LAT;
    sb.push_back(e);
    wait_dones(1, 60);
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (T_GAP + 3) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   bad;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", {31'd0, cs_n}, 1);
    check("rst_ad_sel", {31'd0, ad_sel}, 1);
    check("rst_rd_n", {31'd0, rd_n}, 1);
    check("rst_wr_n", {31'd0, wr_n}, 1);
    check("rst_ad_oe", {31'd0, ad_oe}, 0);
    check("rst_ad_out", {24'd0, ad_out}, 0);
    check("rst_rd_data", {24'd0, rd_data}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_dones", {30'd0, rd_done, wr_done}, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Single read then single write.
    single(1'b0, 8'h21, 8'h00, 8'h45);
    single(1'b1, 8'h41, 8'h30, 8'h00);

    // Hold blocks a pending read; release grants on the next edge.
    @(posedge clk); #1;
    hold = 1'b1; rd_req = 1'b1; rd_addr = 8'h52; ad_in = 8'hA7;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cs_n !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("hold_blocks_grant", bad, 0);
    @(posedge clk); #1;
    hold = 1'b0;
    e.w = 1'b0; e.addr = 8'h52; e.data = 8'hA7; e.cyc = cyc + LAT;
    sb.push_back(e);
    @(posedge clk); #1;
    check("grant_after_hold", {31'd0, busy}, 1);
    wait_dones(1, 60);
    rd_req = 1'b0;
    repeat (T_GAP + 3) @(posedge clk);

    // Both requesting continuously: W, R, W, R round-robin.
    @(posedge clk); #1;
    rd_req = 1'b1; rd_addr = 8'h12; ad_in = 8'h5C;
    wr_req = 1'b1; wr_addr = 8'h34; wr_data = 8'hE1;
    for (int i = 0; i < 4; i++) begin
      e.w    = (i % 2 == 0);
      e.addr = e.w ? 8'h34 : 8'h12;
      e.data = e.w ? 8'hE1 : 8'h5C;
      e.cyc  = cyc + LAT + i * PERIOD;
      sb.push_back(e);
    end
    wait_dones(4, 120);
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (T_GAP + 3) @(posedge clk);

    // Reset during the read data strobe aborts without a done pulse.
    @(posedge clk); #1;
    rd_req = 1'b1; rd_addr = 8'h33; ad_in = 8'h99;
    bad = 1;
    for (int i = 0; i < 40 && bad != 0; i++) begin
      @(negedge clk);
      if (rd_n === 1'b0) bad = 0;
    end
    check("reached_d_pulse", bad, 0);
    reset = 1'b0; rd_req = 1'b0;
    @(posedge clk); #1;
    check("abort_strobes", {29'd0, cs_n, rd_n, wr_n}, 7);
    check("abort_ad_oe", {31'd0, ad_oe}, 0);
    check("abort_rd_data", {24'd0, rd_data}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_rd_done", {31'd0, rd_done}, 0);
    reset = 1'b1;
    repeat (30) @(posedge clk);

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
